// File: rtl/data_path.sv
// data_path
// Accumulator datapath for the small processor core. A 16-bit accumulator
// (AC) is fed through a bus mux that selects either a combinational ALU
// result or the raw external data input. AC loads from the bus on a rising
// clock edge when ld_AC is high, and its value is presented on DataOutput.
//
// Ports:
//   clk               rising-edge clock for AC
//   rst_n             asynchronous active-low reset, clears AC
//   DataInput[15:0]   external operand and bypass data
//   Reset_AC          ALU op: result = 0                   (highest priority)
//   ShiftRight_AC     ALU op: logical shift right by one
//   Add_Input_AC      ALU op: AC + DataInput, carry dropped
//   Increment_AC      ALU op: AC + 1, wraps at FFFF
//   Swaprightleft_AC  ALU op: swap the two bytes of AC
//   Complement_AC     ALU op: bitwise NOT of AC
//   Multiply_AC       ALU op: AC[7:0] * DataInput[7:0]      (lowest priority)
//   alu_on_bus        bus select: 1 = ALU result, 0 = DataInput
//   ld_AC             AC load enable
//   DataOutput[15:0]  current AC value

module data_path (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] DataInput,
  input  logic        Reset_AC,
  input  logic        ShiftRight_AC,
  input  logic        Add_Input_AC,
  input  logic        Increment_AC,
  input  logic        Swaprightleft_AC,
  input  logic        Complement_AC,
  input  logic        Multiply_AC,
  input  logic        alu_on_bus,
  input  logic        ld_AC,
  output logic [15:0] DataOutput
);

  logic [15:0] ac;
  logic [15:0] alu_result;
  logic [15:0] product;
  logic [15:0] bus;

  // Both operands are zero-extended to 16 bits so the full 8x8 product is
  // kept and the upper bytes of AC and DataInput never contribute.
  assign product = {8'h00, ac[7:0]} * {8'h00, DataInput[7:0]};

  // ALU: the if/else chain encodes the fixed operation priority, so several
  // asserted controls resolve to the highest one rather than a blend.
  always_comb begin
    alu_result = ac;
    if (Reset_AC)
      alu_result = 16'h0000;
    else if (ShiftRight_AC)
      alu_result = {1'b0, ac[15:1]};
    else if (Add_Input_AC)
      alu_result = ac + DataInput;
    else if (Increment_AC)
      alu_result = ac + 16'd1;
    else if (Swaprightleft_AC)
      alu_result = {ac[7:0], ac[15:8]};
    else if (Complement_AC)
      alu_result = ~ac;
    else if (Multiply_AC)
      alu_result = product;
  end

  // Plain mux in place of the shared tri-state bus of the original core.
  assign bus = alu_on_bus ? alu_result : DataInput;

  // Accumulator register; Reset_AC only clears it through a normal load,
  // while rst_n clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ac <= 16'h0000;
    else if (ld_AC)
      ac <= bus;
  end

  assign DataOutput = ac;

endmodule

// File: tb/tb_data_path.sv
// tb_data_path
// Self-checking bench for data_path. A table of {controls, data, expected AC}
// records is driven one edge at a time; each expected value is pushed onto a
// scoreboard queue when the stimulus is applied and popped when the
// registered output is sampled after the edge. Hand-written sequences cover
// asynchronous reset and glitches between edges, and a short random run is
// checked against a small reference model.

module tb_data_path;

  // Op vector bit order: reset, shr, add, inc, swap, comp, mul
  localparam logic [6:0] OP_NONE = 7'b0000000;
  localparam logic [6:0] OP_RST  = 7'b1000000;
  localparam logic [6:0] OP_SHR  = 7'b0100000;
  localparam logic [6:0] OP_ADD  = 7'b0010000;
  localparam logic [6:0] OP_INC  = 7'b0001000;
  localparam logic [6:0] OP_SWAP = 7'b0000100;
  localparam logic [6:0] OP_COMP = 7'b0000010;
  localparam logic [6:0] OP_MUL  = 7'b0000001;

  typedef struct {
    logic [6:0]  ops;
    logic        sel;
    logic        ld;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] DataInput;
  logic        Reset_AC;
  logic        ShiftRight_AC;
  logic        Add_Input_AC;
  logic        Increment_AC;
  logic        Swaprightleft_AC;
  logic        Complement_AC;
  logic        Multiply_AC;
  logic        alu_on_bus;
  logic        ld_AC;
  logic [15:0] DataOutput;

  int errors = 0;
  int checks = 0;
  logic [15:0] scoreboard[$];
  vec_t vecs[$];

  data_path dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .DataInput        (DataInput),
    .Reset_AC         (Reset_AC),
    .ShiftRight_AC    (ShiftRight_AC),
    .Add_Input_AC     (Add_Input_AC),
    .Increment_AC     (Increment_AC),
    .Swaprightleft_AC (Swaprightleft_AC),
    .Complement_AC    (Complement_AC),
    .Multiply_AC      (Multiply_AC),
    .alu_on_bus       (alu_on_bus),
    .ld_AC            (ld_AC),
    .DataOutput       (DataOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stalled run: report and stop.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic [6:0] ops, logic sel, logic ld,
                              logic [15:0] din, logic [15:0] exp);
    vec_t v;
    v.ops = ops; v.sel = sel; v.ld = ld; v.din = din; v.exp = exp;
    return v;
  endfunction

  // Reference model of one clock edge, used for the random run.
  function automatic logic [15:0] model_next(logic [15:0] acc, logic [6:0] ops,
                                             logic sel, logic ld, logic [15:0] din);
    logic [15:0] r;
    if (!ld) return acc;
    if (!sel) return din;
    casez (ops)
      7'b1??????: r = 16'h0000;
      7'b01?????: r = acc >> 1;
      7'b001????: r = 16'((32'(acc) + 32'(din)) % 32'h10000);
      7'b0001???: r = 16'((32'(acc) + 32'd1) % 32'h10000);
      7'b00001??: r = {acc[7:0], acc[15:8]};
      7'b000001?: r = acc ^ 16'hFFFF;
      7'b0000001: r = 16'(32'(acc[7:0]) * 32'(din[7:0]));
      default:    r = acc;
    endcase
    return r;
  endfunction

  task automatic driveControls(logic [6:0] ops, logic sel, logic ld, logic [15:0] din);
    {Reset_AC, ShiftRight_AC, Add_Input_AC, Increment_AC,
     Swaprightleft_AC, Complement_AC, Multiply_AC} = ops;
    alu_on_bus = sel;
    ld_AC      = ld;
    DataInput  = din;
  endtask

  // Drive one record at the falling edge and queue its expected result.
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    driveControls(v.ops, v.sel, v.ld, v.din);
    scoreboard.push_back(v.exp);
  endtask

  // Pop the oldest expected value and compare with the output.
  task automatic checkOutput(string name);
    logic [15:0] exp;
    checks++;
    if (scoreboard.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", name, DataOutput);
      return;
    end
    exp = scoreboard.pop_front();
    if (DataOutput !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, DataOutput, exp);
    end
  endtask

  task automatic stepAndCheck(vec_t v, string name);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  initial begin
    logic [15:0] model_ac;
    vec_t v;

    // Reset state before any clock edge.
    rst_n = 1'b0;
    driveControls(OP_NONE, 1'b0, 1'b0, 16'h0000);
    #3;
    scoreboard.push_back(16'h0000);
    checkOutput("reset_initial");

    @(negedge clk);
    rst_n = 1'b1;

    // Load 1234, then assert rst_n mid-cycle: AC clears with no edge.
    stepAndCheck(mk(OP_NONE, 1'b0, 1'b1, 16'h1234, 16'h1234), "bypass_1234");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    scoreboard.push_back(16'h0000);
    checkOutput("async_reset_clears");

    // rst_n held low across an edge wins over a load.
    driveControls(OP_NONE, 1'b0, 1'b1, 16'hABCD);
    @(posedge clk);
    #1;
    scoreboard.push_back(16'h0000);
    checkOutput("reset_over_load");

    @(negedge clk);
    rst_n = 1'b1;

    // Main table: the chained-op walk, load inhibit, multiply, wrap, priority.
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'h1111, 16'h1111));
    vecs.push_back(mk(OP_RST,  1'b1, 1'b1, 16'h0000, 16'h0000));
    vecs.push_back(mk(OP_INC,  1'b1, 1'b1, 16'h0000, 16'h0001));
    vecs.push_back(mk(OP_SWAP, 1'b1, 1'b1, 16'h0000, 16'h0100));
    vecs.push_back(mk(OP_SHR,  1'b1, 1'b1, 16'h0000, 16'h0080));
    vecs.push_back(mk(OP_ADD,  1'b1, 1'b1, 16'hF00F, 16'hF08F));
    vecs.push_back(mk(OP_COMP, 1'b1, 1'b1, 16'h0000, 16'h0F70));
    vecs.push_back(mk(OP_MUL,  1'b1, 1'b0, 16'h0200, 16'h0F70));
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'h0200, 16'h0200));
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'h00FF, 16'h00FF));
    vecs.push_back(mk(OP_MUL,  1'b1, 1'b1, 16'h12FF, 16'hFE01));
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'h0F70, 16'h0F70));
    vecs.push_back(mk(OP_MUL,  1'b1, 1'b1, 16'h0203, 16'h0150));
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF));
    vecs.push_back(mk(OP_INC,  1'b1, 1'b1, 16'h0000, 16'h0000));
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF));
    vecs.push_back(mk(OP_ADD,  1'b1, 1'b1, 16'h0002, 16'h0001));
    vecs.push_back(mk(OP_RST | OP_INC, 1'b1, 1'b1, 16'h0000, 16'h0000));
    vecs.push_back(mk(OP_NONE, 1'b0, 1'b1, 16'h8001, 16'h8001));
    vecs.push_back(mk(OP_SHR | OP_ADD, 1'b1, 1'b1, 16'h1234, 16'h4000));
    vecs.push_back(mk(OP_NONE, 1'b1, 1'b1, 16'h5555, 16'h4000));
    vecs.push_back(mk(OP_NONE, 1'b1, 1'b1, 16'h5555, 16'h4000));
    vecs.push_back(mk(OP_NONE, 1'b1, 1'b1, 16'h5555, 16'h4000));
    vecs.push_back(mk(OP_INC,  1'b1, 1'b1, 16'h0000, 16'h4001));
    vecs.push_back(mk(OP_INC,  1'b1, 1'b1, 16'h0000, 16'h4002));
    vecs.push_back(mk(OP_INC,  1'b1, 1'b1, 16'h0000, 16'h4003));
    vecs.push_back(mk(OP_COMP | OP_MUL, 1'b1, 1'b1, 16'h0002, 16'hBFFC));
    vecs.push_back(mk(OP_SWAP | OP_MUL, 1'b1, 1'b1, 16'h0002, 16'hFCBF));
    foreach (vecs[i])
      stepAndCheck(vecs[i], $sformatf("vec%0d", i));

    // Glitches between edges: ld and ops pulse, but only the level at the
    // edge matters; ld low there means AC holds FCBF.
    @(negedge clk);
    driveControls(OP_COMP, 1'b1, 1'b1, 16'h0000);
    #1 driveControls(OP_INC, 1'b0, 1'b1, 16'h7777);
    #1 driveControls(OP_RST, 1'b1, 1'b0, 16'h0000);
    scoreboard.push_back(16'hFCBF);
    @(posedge clk);
    #1;
    checkOutput("glitch_ld_low");

    // Opposite glitch: ld low between edges, high and bypass at the edge.
    @(negedge clk);
    driveControls(OP_RST, 1'b1, 1'b0, 16'h0000);
    #1 driveControls(OP_NONE, 1'b0, 1'b1, 16'h3C5A);
    scoreboard.push_back(16'h3C5A);
    @(posedge clk);
    #1;
    checkOutput("glitch_ld_high");

    // Random run against the reference model.
    model_ac = 16'h3C5A;
    for (int i = 0; i < 40; i++) begin
      v.ops = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127))
                                          : (7'd1 << $urandom_range(0, 6));
      v.sel = ($urandom_range(0, 3) != 0);
      v.ld  = ($urandom_range(0, 4) != 0);
      v.din = 16'($urandom);
      v.exp = model_next(model_ac, v.ops, v.sel, v.ld, v.din);
      model_ac = v.exp;
      stepAndCheck(v, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
